// File: rtl/raster_pixel_receiver_if.sv
// Framebuffer write port. The master holds FB_ADDR/FB_DATA stable with FB_WE high
// until the slave answers FB_READY; a word transfers in every cycle with FB_WE && FB_READY.
interface raster_pixel_receiver_if #(
    parameter int ADDR_W = 17
);
    logic              FB_WE;
    logic              FB_READY;
    logic [ADDR_W-1:0] FB_ADDR;
    logic [15:0]       FB_DATA;

    modport master (output FB_WE, output FB_ADDR, output FB_DATA, input FB_READY);
    modport slave  (input FB_WE, input FB_ADDR, input FB_DATA, output FB_READY);
endinterface

// File: rtl/raster_pixel_receiver.sv
// Deserialises rasterizer pixels, clips them to the framebuffer and queues writes.
// Optional macro ALPHA_DISCARD_EN: pixels with colour bit 0 clear are treated as clipped.
module raster_pixel_receiver #(
    parameter int FB_W       = 320,
    parameter int FB_H       = 240,
    parameter int FRAC       = 6,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 17
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    VALID,
    input  logic                    PX,
    input  logic                    PY,
    input  logic                    C,
    input  logic                    DONE,
    input  logic                    CLR,
    raster_pixel_receiver_if.master fb,
    output logic                    FRAME_DONE,
    output logic [16:0]             PIX_COUNT,
    output logic [16:0]             CLIP_COUNT,
    output logic                    OVERFLOW,
    output logic                    PROTO_ERR,
    output logic [1:0]              dbg_state
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CRD_W = 16 - FRAC;

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, CHECK = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [15:0]       sx_q, sx_d, sy_q, sy_d, sc_q, sc_d;
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] addr_mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] addr_mem_d [FIFO_DEPTH];
    logic [15:0]       data_mem_q [FIFO_DEPTH];
    logic [15:0]       data_mem_d [FIFO_DEPTH];
    logic [16:0]       pix_cnt_q, pix_cnt_d, clip_cnt_q, clip_cnt_d;
    logic              ovf_q, ovf_d, perr_q, perr_d, done_pend_q, done_pend_d;

    logic [CRD_W-1:0]  x_int, y_int;
    logic [ADDR_W-1:0] pix_addr;
    logic              coord_clip, clipped, check, push, pop;
    logic              fifo_empty, fifo_full, frame_done;

    function automatic logic [16:0] sat_inc(input logic [16:0] v);
        return (v == 17'h1FFFF) ? v : v + 17'd1;
    endfunction

    assign x_int      = sx_q[15:FRAC];
    assign y_int      = sy_q[15:FRAC];
    assign coord_clip = sx_q[15] | sy_q[15] | (32'(x_int) >= 32'(FB_W)) | (32'(y_int) >= 32'(FB_H));
    assign pix_addr   = ADDR_W'(y_int) * ADDR_W'(FB_W) + ADDR_W'(x_int);
`ifdef ALPHA_DISCARD_EN
    assign clipped    = coord_clip | ~sc_q[0];
`else
    assign clipped    = coord_clip;
`endif

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign pop        = !fifo_empty && fb.FB_READY;
    assign check      = (state_q == CHECK);
    assign push       = check && !clipped && (!fifo_full || pop);
    assign frame_done = done_pend_q && (state_q == IDLE) && !VALID && fifo_empty;

    assign fb.FB_WE    = !fifo_empty;
    assign fb.FB_ADDR  = fifo_empty ? '0 : addr_mem_q[rd_ptr_q[PTR_W-1:0]];
    assign fb.FB_DATA  = fifo_empty ? '0 : data_mem_q[rd_ptr_q[PTR_W-1:0]];
    assign FRAME_DONE  = frame_done;
    assign PIX_COUNT   = pix_cnt_q;
    assign CLIP_COUNT  = clip_cnt_q;
    assign OVERFLOW    = ovf_q;
    assign PROTO_ERR   = perr_q;
    assign dbg_state   = state_q;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sx_d      = sx_q;
        sy_d      = sy_q;
        sc_d      = sc_q;
        perr_d    = perr_q;
        case (state_q)
            IDLE: begin
                if (VALID) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                end
            end
            SHIFT: begin
                sx_d      = {sx_q[14:0], PX};
                sy_d      = {sy_q[14:0], PY};
                sc_d      = {sc_q[14:0], C};
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (VALID) perr_d = 1'b1;
                if (bit_cnt_q == 4'd15) state_d = CHECK;
            end
            CHECK: begin
                // A new transfer may start in the classification cycle.
                if (VALID) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                end else begin
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (CLR) perr_d = 1'b0;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        addr_mem_d  = addr_mem_q;
        data_mem_d  = data_mem_q;
        pix_cnt_d   = pix_cnt_q;
        clip_cnt_d  = clip_cnt_q;
        ovf_d       = ovf_q;
        if (push) begin
            addr_mem_d[wr_ptr_q[PTR_W-1:0]] = pix_addr;
            data_mem_d[wr_ptr_q[PTR_W-1:0]] = sc_q;
            wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
        if (check) begin
            if (clipped)   clip_cnt_d = sat_inc(clip_cnt_q);
            else if (push) pix_cnt_d  = sat_inc(pix_cnt_q);
            else           ovf_d      = 1'b1;
        end
        if (CLR) begin
            pix_cnt_d  = '0;
            clip_cnt_d = '0;
            ovf_d      = 1'b0;
        end
        done_pend_d = DONE | (done_pend_q & ~frame_done);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            sx_q        <= '0;
            sy_q        <= '0;
            sc_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pix_cnt_q   <= '0;
            clip_cnt_q  <= '0;
            ovf_q       <= 1'b0;
            perr_q      <= 1'b0;
            done_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            sc_q        <= sc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pix_cnt_q   <= pix_cnt_d;
            clip_cnt_q  <= clip_cnt_d;
            ovf_q       <= ovf_d;
            perr_q      <= perr_d;
            done_pend_q <= done_pend_d;
        end
    end

    always_ff @(posedge CLK) begin
        addr_mem_q <= addr_mem_d;
        data_mem_q <= data_mem_d;
    end
endmodule
